stream_rr_arbiter: RTL
======================

# stream_rr_arbiter

Packet-level round-robin arbiter and multiplexer that shares one valid/ready stream sink (for example a weight/activation loader or a shared memory write port) between `NUM_PORTS` stream sources. A source keeps its grant until the last beat of its packet has been accepted. Forwarded beats pass through a single registered output stage. The block sits between the per-lane producers and the shared datapath resource, and replaces single-cycle request/grant arbitration wherever the transfers are multi-beat.

## Interface
Parameters
- `NUM_PORTS`, default 4: number of source ports, must be ≥ 1.
- `DATA_WIDTH`, default 32: width of the data bus on each port.
- `SEL_WIDTH`, default `NUM_PORTS>1 ? $clog2(NUM_PORTS) : 1`: width of the port-index fields.

Ports
- `clk`  in  1: clock, all logic on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `s_data`  in  `NUM_PORTS*DATA_WIDTH`: source data, port i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `s_valid`  in  `NUM_PORTS`: source beat valid, one bit per port.
- `s_last`  in  `NUM_PORTS`: marks the final beat of a packet, one bit per port.
- `s_ready`  out  `NUM_PORTS`: source beat accepted, combinational.
- `m_data`  out  `DATA_WIDTH`: output data, registered.
- `m_valid`  out  1: output beat valid, registered.
- `m_last`  out  1: output last-beat flag, registered.
- `m_sel`  out  `SEL_WIDTH`: index of the source port that produced the current output beat, registered.
- `m_ready`  in  1: sink ready.
- `busy`  out  1: high while a packet holds the grant (state LOCKED).

## Operation
- State machine with two states.
  - IDLE: no grant is held and `s_ready` = 0.
  - LOCKED: the port `grant_idx` owns the output.
- **IDLE → LOCKED** when any `s_valid` bit is set.
  - The winner is the first port with `s_valid` set, scanning `ptr, ptr+1, …, NUM_PORTS-1, 0, …` (modulo wrap).
  - The winner is registered into `grant_idx`.
- **LOCKED behaviour**
  - `s_ready[grant_idx] = !m_valid || m_ready`.
  - All other `s_ready` bits are 0.
  - An accepted beat (`s_valid[grant_idx] && s_ready[grant_idx]`) loads `m_data`, `m_last` and `m_sel = grant_idx`, and sets `m_valid` = 1.
- **Output register**
  - If `m_valid && m_ready` and no new beat is accepted, `m_valid` clears on the next edge.
  - A new beat accepted in the same cycle as an output handshake keeps `m_valid` = 1 with no bubble.
- **LOCKED → IDLE** on the edge at which a beat with `s_last[grant_idx]` = 1 is accepted. On the same edge `ptr` ← `(grant_idx+1) mod NUM_PORTS`.
- **Owner deasserts `s_valid` mid-packet:** the block stays LOCKED and waits. Other ports are never granted until `last` arrives.
- **Requests without data:** changes on `s_valid`/`s_data` of non-granted ports have no effect while LOCKED.
- **Single-port build:** with `NUM_PORTS`=1, `ptr` and `grant_idx` stay 0 and `m_sel` stays 0.
- **Reset values:**
  - Outputs: `m_valid`=0, `m_last`=0, `m_data`=0, `m_sel`=0, `busy`=0, `s_ready`=0.
  - Internal: state IDLE, `ptr`=0, `grant_idx`=0.
- **Reset mid-packet:** the packet is abandoned and the output beat is dropped. The next arbitration starts from port 0.

## Timing
- **Arbitration latency:** `s_valid` first seen in IDLE at cycle 0 → `busy`=1 and `s_ready[winner]`=1 in cycle 1. First beat appears on `m_valid` in cycle 2.
- **Within a packet:** throughput is 1 beat/cycle while `m_ready`=1. Latency from source to output is 1 cycle.
- **Between packets:** after the `last` beat is accepted there is exactly one IDLE cycle before the next grant. Alternating 1-beat packets therefore reach 1 beat per 2 cycles.
- **Backpressure:** `s_ready` follows `m_ready` combinationally when `m_valid`=1. There is no combinational path from any `s_valid` to `s_ready`.
- **`busy`:** equals the LOCKED state and changes only on clock edges.

## Test plan
- **Reset, then port 2 alone:** reset, then send a 3-beat packet on port 2 (data 0xA0, 0xA1, 0xA2) with `m_ready`=1.
  - `busy` rises in cycle 1.
  - `m_data` carries 0xA0/0xA1/0xA2 in cycles 2–4, with `m_sel`=2 and `m_last` only on 0xA2.
  - `busy` falls after the last beat.
- **Round-robin fairness:** all 4 ports continuously offer 1-beat packets.
  - `m_sel` sequence is 0,1,2,3,0,1,…
  - Output carries 1 beat per 2 cycles.
- **Lock hold:** port 1 is granted a 4-beat packet; port 0 asserts `s_valid` and port 1 drops `s_valid` for 3 cycles mid-packet.
  - `s_ready[0]` stays 0 throughout and there is no beat from port 0.
  - All 4 port-1 beats arrive in order, then port 0 is granted next.
- **Backpressure:** toggle `m_ready` 1,0,0,1,… during a 5-beat packet.
  - No beat is lost or duplicated.
  - `m_data` is stable while `m_valid`=1 and `m_ready`=0.
  - `s_ready` is 0 whenever `m_valid`=1 and `m_ready`=0.
- **Wrap-around:** `ptr`=3 after a port-2 packet; ports 0 and 3 request simultaneously. Port 3 is granted first, then port 0.
- **Reset mid-packet:** assert `rst` during beat 2 of a port-1 packet.
  - Next cycle `m_valid`=0 and `busy`=0.
  - Subsequent simultaneous requests from ports 0 and 1 grant port 0 first.

Source files
------------

// File: rtl/stream_rr_arbiter.sv
// Packet-level round-robin arbiter/mux: one source owns the shared sink from
// grant until its last beat is accepted; beats leave through a single output register.
module stream_rr_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_PORTS-1:0]            s_valid,
    input  logic [NUM_PORTS-1:0]            s_last,
    output logic [NUM_PORTS-1:0]            s_ready,
    output logic [DATA_WIDTH-1:0]           m_data,
    output logic                            m_valid,
    output logic                            m_last,
    output logic [SEL_WIDTH-1:0]            m_sel,
    input  logic                            m_ready,
    output logic                            busy
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                   state;
    logic [SEL_WIDTH-1:0]     ptr;
    logic [SEL_WIDTH-1:0]     grant_idx;
    logic [SEL_WIDTH-1:0]     winner;
    logic [SEL_WIDTH-1:0]     ptr_next;
    logic [SEL_WIDTH:0]       wsum;
    logic [2*NUM_PORTS-1:0]   rot;
    logic [DATA_WIDTH-1:0]    grant_data;
    logic                     grant_valid;
    logic                     grant_last;
    logic                     out_free;
    logic                     accept;
    logic                     any_req;

    assign busy     = (state == LOCKED);
    assign out_free = !m_valid || m_ready;
    assign any_req  = |s_valid;
    assign accept   = busy && out_free && grant_valid;
    assign ptr_next = (grant_idx == SEL_WIDTH'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;

    // Ready depends only on state and the output register, never on s_valid.
    always_comb begin
        s_ready = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            s_ready[i] = busy && out_free && (grant_idx == SEL_WIDTH'(i));
    end

    always_comb begin
        grant_data  = '0;
        grant_valid = 1'b0;
        grant_last  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_idx == SEL_WIDTH'(i)) begin
                grant_data  = s_data[i*DATA_WIDTH +: DATA_WIDTH];
                grant_valid = s_valid[i];
                grant_last  = s_last[i];
            end
        end
    end

    // Rotate requests so bit 0 is the port at ptr; the lowest set offset wins.
    always_comb begin
        rot  = {s_valid, s_valid} >> ptr;
        wsum = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--)
            if (rot[k]) wsum = {1'b0, ptr} + (SEL_WIDTH+1)'(k);
        if (wsum >= (SEL_WIDTH+1)'(NUM_PORTS))
            wsum = wsum - (SEL_WIDTH+1)'(NUM_PORTS);
        winner = wsum[SEL_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            grant_idx <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            m_data    <= '0;
            m_sel     <= '0;
        end else begin
            if (accept) begin
                m_valid <= 1'b1;
                m_data  <= grant_data;
                m_last  <= grant_last;
                m_sel   <= grant_idx;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= LOCKED;
                        grant_idx <= winner;
                    end
                end
                LOCKED: begin
                    if (accept && grant_last) begin
                        state <= IDLE;
                        ptr   <= ptr_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
